mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one downstream memory port between the instruction-fetch requester (I, read-only) and the data requester (D, read/write).
- The downstream port uses the team's magic-memory handshake: address and masks are presented, and `resp` returns one or more cycles later.
- Sits between the CPU's fetch/LSU ports and the single-port memory model or cache.
- Buffers one pending request per side, arbitrates round-robin, issues one downstream transaction at a time, routes the response back, and flags protocol violations and hangs.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles a downstream transaction may wait for `m_resp` before `err` is set. 0 disables the watchdog.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- i_addr  in  32  I request address, word aligned.
- i_rmask  in  4  I byte read mask; nonzero for one cycle = new request.
- i_rdata  out  32  I read data; valid only while i_resp=1.
- i_resp  out  1  I response, one-cycle pulse.
- d_addr  in  32  D request address.
- d_rmask  in  4  D read mask; nonzero for one cycle = read request.
- d_wmask  in  4  D write mask; nonzero for one cycle = write request.
- d_wdata  in  32  D write data.
- d_rdata  out  32  D read data; valid only while d_resp=1.
- d_resp  out  1  D response pulse (reads and writes).
- m_addr  out  32  downstream address.
- m_rmask  out  4  downstream read mask.
- m_wmask  out  4  downstream write mask.
- m_wdata  out  32  downstream write data.
- m_rdata  in  32  downstream read data.
- m_resp  in  1  downstream response.
- err  out  1  sticky protocol/timeout error.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE; both pending slots empty.
  - last_grant=D, so I wins the first tie.
  - m_addr, m_wdata, m_rmask, m_wmask = 0; err=0; watchdog=0.
  - Reset mid-transaction drops everything in flight. The memory must be reset alongside the arbiter.
- Capture:
  - A cycle with nonzero i_rmask latches {addr, rmask} into the I slot.
  - A cycle with nonzero d_rmask or d_wmask latches {addr, rmask, wmask, wdata} into the D slot.
- One outstanding request per side:
  - A new request while that side's slot is occupied sets err, unless the slot is being completed that same cycle.
  - Request and completion in the same cycle: the set wins, so the new request is retained.
  - d_rmask and d_wmask both nonzero: set err; capture as a write.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if either slot is occupied, grant (only one occupied → that side; both → the side != last_grant). Load m_* from the granted slot, record owner, go to ISSUE.
  - ISSUE: m_* masks are nonzero for exactly this one cycle. Go to WAIT; clear watchdog.
  - WAIT: m_rmask and m_wmask are 0; watchdog increments each cycle.
    - On m_resp=1: assert the owner's resp for this cycle only; clear the owner's slot; last_grant=owner.
    - In the same cycle, if the other slot is occupied, load m_* and go directly to ISSUE (back-to-back); otherwise go to IDLE.
    - A same-cycle re-request from the owner is only eligible from the next cycle onward.
- Response path:
  - i_resp = (state==WAIT && owner==I && m_resp); d_resp likewise.
  - i_rdata = d_rdata = m_rdata, combinational pass-through.
  - For D writes, d_resp pulses and d_rdata is don't-care.
- Latency: request at cycle T → m_* issued at T+2 → with a 1-cycle memory, resp at T+3.
- Watchdog: if the count reaches TIMEOUT_CYCLES (nonzero) while in WAIT, set err and remain in WAIT.
- Spurious response: m_resp=1 in IDLE or ISSUE sets err and is otherwise ignored.
- err is sticky until reset.
- m_addr and m_wdata hold their last values outside ISSUE.
- Fairness: under continuous load from both sides, grants strictly alternate I, D, I, D.

Decomposition:
- Package mem_arb_pkg holds:
  - enum arb_state_t {IDLE, ISSUE, WAIT};
  - enum arb_owner_t {OWN_I, OWN_D};
  - struct mem_req_t {addr[31:0], rmask[3:0], wmask[3:0], wdata[31:0]}.
- Sub-module mem_arb_req_slot: a one-entry pending buffer with capture, clear, set-wins-over-clear and overflow-error output. Instantiated twice (the I instance ties wmask=0).

Test Plan:
- Single I read: i_addr=0x1000, i_rmask=0xF at T; memory holds 0xDEADBEEF → m_rmask=0xF only at T+2; i_resp=1, i_rdata=0xDEADBEEF at T+3; err=0.
- Simultaneous I read 0x2000 and D read 0x3000 at T after reset → I issued at T+2 and responds at T+3; D issued at T+4 and responds at T+5.
- D write then read back: d_wmask=0x3, d_wdata=0x12345678 to 0x4000 (memory initially 0xAAAAAAAA) → d_resp; then d_rmask=0xF to 0x4000 → d_rdata=0xAAAA5678.
- Continuous I and D requests for 8 transactions → grant order I, D, I, D, I, D, I, D; no request lost; err=0.
- Protocol violations, each in a fresh reset:
  - second i_rmask=0xF one cycle after the first, before i_resp → err=1 and held;
  - d_rmask=0xF with d_wmask=0xF → err=1;
  - m_resp=1 while IDLE → err=1.
- TIMEOUT_CYCLES=16, memory never responds → err rises 16 cycles after entering WAIT; asserting rst=0 for one edge clears err, empties both slots and forces m_rmask=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_arb_pkg
// Brief  : Shared types for the I/D memory port arbiter.
// Rev    : 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mem_req_t;

    localparam mem_req_t REQ_NONE = '0;

    function automatic arb_owner_t other_side(input arb_owner_t o);
        return (o == OWN_I) ? OWN_D : OWN_I;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter_if
// Brief  : Fetch, LSU and downstream magic-memory signals of the arbiter.
// Rev    : 1.0
// ============================================================================
interface mem_port_arbiter_if;
    logic [31:0] i_addr;
    logic [3:0]  i_rmask;
    logic [31:0] i_rdata;
    logic        i_resp;

    logic [31:0] d_addr;
    logic [3:0]  d_rmask;
    logic [3:0]  d_wmask;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_resp;

    logic [31:0] m_addr;
    logic [3:0]  m_rmask;
    logic [3:0]  m_wmask;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_resp;

    // Arbiter view.
    modport slave (
        input  i_addr, i_rmask, d_addr, d_rmask, d_wmask, d_wdata, m_rdata, m_resp,
        output i_rdata, i_resp, d_rdata, d_resp, m_addr, m_rmask, m_wmask, m_wdata
    );

    // Requester/memory environment view.
    modport master (
        output i_addr, i_rmask, d_addr, d_rmask, d_wmask, d_wdata, m_rdata, m_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, m_addr, m_rmask, m_wmask, m_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arb_req_slot.sv
`default_nettype none
// ============================================================================
// Module : mem_arb_req_slot
// Brief  : One-entry pending request buffer; capture wins over clear.
// Rev    : 1.0
// ============================================================================
module mem_arb_req_slot
    import mem_arb_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     rst,
    input  wire logic     cap_i,
    input  wire mem_req_t req_i,
    input  wire logic     clr_i,
    output logic          valid_o,
    output mem_req_t      req_o,
    output logic          ovf_o
);

    logic     valid_q, valid_d;
    mem_req_t req_q, req_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            req_q   <= REQ_NONE;
        end else begin
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        valid_d = valid_q;
        req_d   = req_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end
        if (cap_i) begin
            valid_d = 1'b1;
            req_d   = req_i;
        end
    end

    assign valid_o = valid_q;
    assign req_o   = req_q;
    // A slot being retired this cycle may legally accept its successor.
    assign ovf_o   = cap_i && valid_q && !clr_i;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Round-robin sharing of one magic-memory port between I and D.
// Rev    : 1.0
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_port_arbiter_if.slave bus,
    output logic              err_o
);

    localparam int              WDW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WDW-1:0]  WD_LIMIT = WDW'(TIMEOUT_CYCLES);
    localparam bit              WD_EN    = (TIMEOUT_CYCLES != 0);

    arb_state_t     state_q, state_d;
    arb_owner_t     owner_q, owner_d;
    arb_owner_t     last_q, last_d;
    mem_req_t       m_q, m_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic           err_q, err_d;

    logic     w_i_cap, w_d_cap, w_d_both;
    logic     w_i_clr, w_d_clr, w_resp;
    logic     w_i_valid, w_d_valid, w_i_ovf, w_d_ovf;
    mem_req_t w_i_req_in, w_d_req_in, w_i_req, w_d_req;

    assign w_i_cap  = |bus.i_rmask;
    assign w_d_cap  = (|bus.d_rmask) || (|bus.d_wmask);
    assign w_d_both = (|bus.d_rmask) && (|bus.d_wmask);

    assign w_i_req_in = '{addr: bus.i_addr, rmask: bus.i_rmask, wmask: 4'h0, wdata: 32'h0};
    // A request carrying both masks is treated as a pure write.
    assign w_d_req_in = '{addr:  bus.d_addr,
                          rmask: w_d_both ? 4'h0 : bus.d_rmask,
                          wmask: bus.d_wmask,
                          wdata: bus.d_wdata};

    assign w_resp  = (state_q == WAIT) && bus.m_resp;
    assign w_i_clr = w_resp && (owner_q == OWN_I);
    assign w_d_clr = w_resp && (owner_q == OWN_D);

    mem_arb_req_slot u_slot_i (
        .clk     (clk),
        .rst     (rst),
        .cap_i   (w_i_cap),
        .req_i   (w_i_req_in),
        .clr_i   (w_i_clr),
        .valid_o (w_i_valid),
        .req_o   (w_i_req),
        .ovf_o   (w_i_ovf)
    );

    mem_arb_req_slot u_slot_d (
        .clk     (clk),
        .rst     (rst),
        .cap_i   (w_d_cap),
        .req_i   (w_d_req_in),
        .clr_i   (w_d_clr),
        .valid_o (w_d_valid),
        .req_o   (w_d_req),
        .ovf_o   (w_d_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            last_q  <= OWN_D;
            m_q     <= REQ_NONE;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            m_q     <= m_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        m_d     = m_q;
        wd_d    = wd_q;
        err_d   = err_q || w_i_ovf || w_d_ovf || w_d_both
                  || ((state_q != WAIT) && bus.m_resp);

        case (state_q)
            IDLE: begin
                if (w_i_valid && w_d_valid) begin
                    owner_d = other_side(last_q);
                    m_d     = (other_side(last_q) == OWN_I) ? w_i_req : w_d_req;
                    state_d = ISSUE;
                end else if (w_i_valid) begin
                    owner_d = OWN_I;
                    m_d     = w_i_req;
                    state_d = ISSUE;
                end else if (w_d_valid) begin
                    owner_d = OWN_D;
                    m_d     = w_d_req;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.m_resp) begin
                    last_d = owner_q;
                    // Owner's same-cycle re-request is not eligible yet.
                    if ((owner_q == OWN_I) ? w_d_valid : w_i_valid) begin
                        owner_d = other_side(owner_q);
                        m_d     = (owner_q == OWN_I) ? w_d_req : w_i_req;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (WD_EN && (wd_q != WD_LIMIT)) begin
                    wd_d = wd_q + 1'b1;
                    if (wd_d == WD_LIMIT) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.m_addr  = m_q.addr;
    assign bus.m_wdata = m_q.wdata;
    assign bus.m_rmask = (state_q == ISSUE) ? m_q.rmask : 4'h0;
    assign bus.m_wmask = (state_q == ISSUE) ? m_q.wmask : 4'h0;

    assign bus.i_resp  = w_i_clr;
    assign bus.d_resp  = w_d_clr;
    assign bus.i_rdata = bus.m_rdata;
    assign bus.d_rdata = bus.m_rdata;

    assign err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Directed self-checking bench with a one-cycle magic-memory model.
// Rev    : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    logic err;
    logic mem_en;
    logic spur;
    logic mem_resp_q;
    logic [31:0] mem_rdata_q;
    logic [31:0] mem [16];

    int checks;
    int failures;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .err_o (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.m_resp  = mem_resp_q | spur;
    assign bus.m_rdata = mem_rdata_q;

    // Memory contents: word k holds {8{k}}, except 0x1000 and 0x4000.
    always @(posedge clk) begin
        if (!rst) begin
            mem_resp_q  <= 1'b0;
            mem_rdata_q <= 32'h0;
            for (int k = 0; k < 16; k++) mem[k] <= {8{4'(k)}};
            mem[1] <= 32'hDEADBEEF;
            mem[4] <= 32'hAAAAAAAA;
        end else begin
            mem_resp_q <= 1'b0;
            if (mem_en && ((|bus.m_rmask) || (|bus.m_wmask))) begin
                mem_resp_q  <= 1'b1;
                mem_rdata_q <= mem[bus.m_addr[15:12]];
                for (int b = 0; b < 4; b++)
                    if (bus.m_wmask[b]) mem[bus.m_addr[15:12]][b*8 +: 8] <= bus.m_wdata[b*8 +: 8];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.i_addr  = 32'h0;
        bus.i_rmask = 4'h0;
        bus.d_addr  = 32'h0;
        bus.d_rmask = 4'h0;
        bus.d_wmask = 4'h0;
        bus.d_wdata = 32'h0;
        spur        = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        mem_en = 1'b1;
        tick();
        tick();
        rst = 1'b1;
    endtask

    int i_issued, d_issued, i_resps, d_resps, grants;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        mem_en   = 1'b1;
        clear_inputs();

        // Reset state
        do_reset();
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_m_rmask", 32'(bus.m_rmask), 32'd0);
        chk("rst_m_wmask", 32'(bus.m_wmask), 32'd0);
        chk("rst_m_addr", bus.m_addr, 32'h0);
        chk("rst_m_wdata", bus.m_wdata, 32'h0);

        // Single I read
        bus.i_addr = 32'h1000; bus.i_rmask = 4'hF;
        chk("t1_T_m_rmask", 32'(bus.m_rmask), 32'd0);
        tick(); bus.i_rmask = 4'h0;
        chk("t1_T1_m_rmask", 32'(bus.m_rmask), 32'd0);
        tick();
        chk("t1_T2_m_rmask", 32'(bus.m_rmask), 32'hF);
        chk("t1_T2_m_addr", bus.m_addr, 32'h1000);
        chk("t1_T2_i_resp", 32'(bus.i_resp), 32'd0);
        tick();
        chk("t1_T3_i_resp", 32'(bus.i_resp), 32'd1);
        chk("t1_T3_i_rdata", bus.i_rdata, 32'hDEADBEEF);
        chk("t1_T3_m_rmask", 32'(bus.m_rmask), 32'd0);
        chk("t1_T3_err", 32'(err), 32'd0);
        tick();
        chk("t1_T4_i_resp", 32'(bus.i_resp), 32'd0);

        // Simultaneous I and D reads after reset: I wins the first tie
        do_reset();
        bus.i_addr = 32'h2000; bus.i_rmask = 4'hF;
        bus.d_addr = 32'h3000; bus.d_rmask = 4'hF;
        tick(); bus.i_rmask = 4'h0; bus.d_rmask = 4'h0;
        tick();
        chk("t2_T2_m_addr", bus.m_addr, 32'h2000);
        chk("t2_T2_m_rmask", 32'(bus.m_rmask), 32'hF);
        tick();
        chk("t2_T3_i_resp", 32'(bus.i_resp), 32'd1);
        chk("t2_T3_i_rdata", bus.i_rdata, 32'h22222222);
        chk("t2_T3_d_resp", 32'(bus.d_resp), 32'd0);
        tick();
        chk("t2_T4_m_addr", bus.m_addr, 32'h3000);
        chk("t2_T4_m_rmask", 32'(bus.m_rmask), 32'hF);
        tick();
        chk("t2_T5_d_resp", 32'(bus.d_resp), 32'd1);
        chk("t2_T5_d_rdata", bus.d_rdata, 32'h33333333);
        chk("t2_T5_err", 32'(err), 32'd0);

        // D partial write then full read back
        do_reset();
        bus.d_addr = 32'h4000; bus.d_wmask = 4'h3; bus.d_wdata = 32'h12345678;
        tick(); bus.d_wmask = 4'h0;
        tick();
        chk("t3_w_m_wmask", 32'(bus.m_wmask), 32'h3);
        chk("t3_w_m_rmask", 32'(bus.m_rmask), 32'h0);
        chk("t3_w_m_wdata", bus.m_wdata, 32'h12345678);
        tick();
        chk("t3_w_d_resp", 32'(bus.d_resp), 32'd1);
        tick();
        bus.d_rmask = 4'hF;
        tick(); bus.d_rmask = 4'h0;
        tick(); tick();
        chk("t3_r_d_resp", 32'(bus.d_resp), 32'd1);
        chk("t3_r_d_rdata", bus.d_rdata, 32'hAAAA5678);

        // Continuous load from both sides: strict alternation
        do_reset();
        bus.i_addr = 32'h5000; bus.d_addr = 32'h6000;
        bus.i_rmask = 4'hF; bus.d_rmask = 4'hF;
        i_issued = 1; d_issued = 1; i_resps = 0; d_resps = 0; grants = 0;
        for (int c = 0; c < 60 && (i_resps + d_resps) < 8; c++) begin
            tick();
            bus.i_rmask = 4'h0; bus.d_rmask = 4'h0;
            if (bus.m_rmask != 4'h0) begin
                chk($sformatf("t4_grant%0d", grants), bus.m_addr,
                    (grants % 2 == 0) ? 32'h5000 : 32'h6000);
                grants++;
            end
            if (bus.i_resp) begin
                chk("t4_i_rdata", bus.i_rdata, 32'h55555555);
                i_resps++;
                if (i_issued < 4) begin bus.i_rmask = 4'hF; i_issued++; end
            end
            if (bus.d_resp) begin
                chk("t4_d_rdata", bus.d_rdata, 32'h66666666);
                d_resps++;
                if (d_issued < 4) begin bus.d_rmask = 4'hF; d_issued++; end
            end
        end
        chk("t4_grants", 32'(grants), 32'd8);
        chk("t4_i_resps", 32'(i_resps), 32'd4);
        chk("t4_d_resps", 32'(d_resps), 32'd4);
        chk("t4_err", 32'(err), 32'd0);

        // Second I request before the first completes
        do_reset();
        bus.i_addr = 32'h1000; bus.i_rmask = 4'hF;
        tick();
        chk("t5a_T1_err", 32'(err), 32'd0);
        tick(); bus.i_rmask = 4'h0;
        chk("t5a_T2_err", 32'(err), 32'd1);
        tick(); tick(); tick(); tick();
        chk("t5a_held_err", 32'(err), 32'd1);

        // D read and write masks together
        do_reset();
        bus.d_addr = 32'h7000; bus.d_rmask = 4'hF; bus.d_wmask = 4'hF;
        tick(); bus.d_rmask = 4'h0; bus.d_wmask = 4'h0;
        chk("t5b_err", 32'(err), 32'd1);

        // Spurious m_resp while idle
        do_reset();
        tick();
        chk("t5c_pre_err", 32'(err), 32'd0);
        spur = 1'b1;
        tick(); spur = 1'b0;
        chk("t5c_err", 32'(err), 32'd1);

        // Watchdog with a silent memory, then reset recovery
        do_reset();
        mem_en = 1'b0;
        bus.i_addr = 32'h1000; bus.i_rmask = 4'hF;
        tick(); bus.i_rmask = 4'h0;
        tick();
        tick();
        for (int k = 0; k < 15; k++) tick();
        chk("t6_T18_err", 32'(err), 32'd0);
        tick();
        chk("t6_T19_err", 32'(err), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("t6_rst_err", 32'(err), 32'd0);
        chk("t6_rst_m_rmask", 32'(bus.m_rmask), 32'd0);
        mem_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t6_idle%0d_m_rmask", k), 32'(bus.m_rmask), 32'd0);
        end
        chk("t6_final_err", 32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL tb_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
